dmem_arbiter: RTL and testbench

// Shares the single data memory port between the pipeline memory stage (CPU) and a debug/loader

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter, data memory and pipeline.
package dmem_arbiter_pkg;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Access size encoding used on every memory-side size bus
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Counter width able to hold 0..max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU M-stage has priority, debug port is aged
// so it is guaranteed a slot, and debug may halt the CPU for bulk transfers.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_RUN  | CPU has priority; debug served when CPU idle or aged out
//   ST_HALT | CPU held off; debug owns memory every cycle it is valid
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32,
  parameter int MP_MAX_WAIT   = 4
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     icpu_req,
  input  logic                     icpu_wen,
  input  logic [1:0]               icpu_be,
  input  logic [MP_ADDR_WIDTH-1:0] icpu_addr,
  input  logic [MP_DATA_WIDTH-1:0] icpu_wdata,
  output logic [MP_DATA_WIDTH-1:0] ocpu_rdata,
  output logic                     ocpu_stall,
  input  logic                     idbg_valid,
  output logic                     odbg_ready,
  input  logic                     idbg_wen,
  input  logic [1:0]               idbg_be,
  input  logic [MP_ADDR_WIDTH-1:0] idbg_addr,
  input  logic [MP_DATA_WIDTH-1:0] idbg_wdata,
  output logic                     odbg_rvalid,
  output logic [MP_DATA_WIDTH-1:0] odbg_rdata,
  input  logic                     idbg_halt,
  output logic                     ohalted,
  output logic                     omem_wen,
  output logic [1:0]               omem_be,
  output logic [MP_ADDR_WIDTH-1:0] omem_addr,
  output logic [MP_DATA_WIDTH-1:0] omem_wdata,
  input  logic [MP_DATA_WIDTH-1:0] imem_rdata
);

  localparam int WC_W = cnt_width(MP_MAX_WAIT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MP_MAX_WAIT);

  logic [0:0]      state_q;
  logic [WC_W-1:0] wait_cnt_q;
  logic            grant_dbg;
  logic            grant_cpu;
  logic            halted;

  assign halted = (state_q == ST_HALT);

  // Arbitration: debug wins when CPU is idle, when it has aged out, or when halted
  always_comb begin
    grant_dbg = 1'b0;
    if (halted) begin
      grant_dbg = idbg_valid;
    end else begin
      grant_dbg = idbg_valid & (~icpu_req | (wait_cnt_q == WC_MAX));
    end
  end

  assign ocpu_stall = icpu_req & (grant_dbg | halted);
  assign grant_cpu  = icpu_req & ~ocpu_stall;
  assign odbg_ready = grant_dbg;
  assign ohalted    = halted;
  assign ocpu_rdata = imem_rdata;

  // Memory-side mux; only the granted requester can ever drive a write
  always_comb begin
    if (grant_dbg) begin
      omem_wen   = idbg_wen;
      omem_be    = idbg_be;
      omem_addr  = idbg_addr;
      omem_wdata = idbg_wdata;
    end else begin
      omem_wen   = grant_cpu & icpu_wen;
      omem_be    = icpu_be;
      omem_addr  = icpu_addr;
      omem_wdata = icpu_wdata;
    end
  end

  // Run/halt FSM; a halt request only affects arbitration from the next cycle
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (idbg_halt)  state_q <= ST_HALT;
        ST_HALT: if (!idbg_halt) state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Aging counter: counts cycles a valid debug request has lost to the CPU
  always_ff @(posedge iclk) begin
    if (irst) begin
      wait_cnt_q <= '0;
    end else if (halted || grant_dbg || !idbg_valid) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WC_MAX) begin
      wait_cnt_q <= wait_cnt_q + WC_W'(1);
    end
  end

  // Debug read response: capture async read data, pulse rvalid for one cycle
  always_ff @(posedge iclk) begin
    if (irst) begin
      odbg_rvalid <= 1'b0;
      odbg_rdata  <= '0;
    end else begin
      odbg_rvalid <= grant_dbg & ~idbg_wen;
      if (grant_dbg && !idbg_wen) begin
        odbg_rdata <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by constrained-random
// traffic, all checked against a cycle-level reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 4;

  logic          iclk = 1'b0;
  logic          irst;
  logic          icpu_req, icpu_wen;
  logic [1:0]    icpu_be;
  logic [AW-1:0] icpu_addr;
  logic [DW-1:0] icpu_wdata, ocpu_rdata;
  logic          ocpu_stall;
  logic          idbg_valid, odbg_ready, idbg_wen;
  logic [1:0]    idbg_be;
  logic [AW-1:0] idbg_addr;
  logic [DW-1:0] idbg_wdata;
  logic          odbg_rvalid;
  logic [DW-1:0] odbg_rdata;
  logic          idbg_halt, ohalted;
  logic          omem_wen;
  logic [1:0]    omem_be;
  logic [AW-1:0] omem_addr;
  logic [DW-1:0] omem_wdata, imem_rdata;

  dmem_arbiter #(.MP_DATA_WIDTH(DW), .MP_ADDR_WIDTH(AW), .MP_MAX_WAIT(MW)) dut (
    .iclk(iclk), .irst(irst),
    .icpu_req(icpu_req), .icpu_wen(icpu_wen), .icpu_be(icpu_be), .icpu_addr(icpu_addr),
    .icpu_wdata(icpu_wdata), .ocpu_rdata(ocpu_rdata), .ocpu_stall(ocpu_stall),
    .idbg_valid(idbg_valid), .odbg_ready(odbg_ready), .idbg_wen(idbg_wen), .idbg_be(idbg_be),
    .idbg_addr(idbg_addr), .idbg_wdata(idbg_wdata), .odbg_rvalid(odbg_rvalid),
    .odbg_rdata(odbg_rdata), .idbg_halt(idbg_halt), .ohalted(ohalted),
    .omem_wen(omem_wen), .omem_be(omem_be), .omem_addr(omem_addr), .omem_wdata(omem_wdata),
    .imem_rdata(imem_rdata)
  );

  always #5 iclk = ~iclk;

  // Data memory behind the arbiter: async word read, clocked sized write
  logic [7:0] env_mem [0:1023];
  logic [9:0] env_a;
  assign env_a = {omem_addr[9:2], 2'b00};
  assign imem_rdata = {env_mem[env_a | 10'd3], env_mem[env_a | 10'd2],
                       env_mem[env_a | 10'd1], env_mem[env_a]};

  always @(posedge iclk) begin
    if (omem_wen) begin
      case (omem_be)
        SZ_BYTE: env_mem[omem_addr[9:0]] = omem_wdata[7:0];
        SZ_HALF: begin
          env_mem[{omem_addr[9:1], 1'b0}] = omem_wdata[7:0];
          env_mem[{omem_addr[9:1], 1'b1}] = omem_wdata[15:8];
        end
        SZ_WORD: begin
          env_mem[{omem_addr[9:2], 2'd0}] = omem_wdata[7:0];
          env_mem[{omem_addr[9:2], 2'd1}] = omem_wdata[15:8];
          env_mem[{omem_addr[9:2], 2'd2}] = omem_wdata[23:16];
          env_mem[{omem_addr[9:2], 2'd3}] = omem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // Reference model state
  logic [7:0]  sh [0:1023];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          known = 0;
  bit          m_halted = 0;
  bit          m_pending = 0;
  int          m_since = 0;
  bit          m_rvalid = 0;
  logic [31:0] m_rdata = 0;
  bit          m_last_gdbg = 0;
  bit          m_last_stall = 0;

  logic [31:0] obs_cpu_rdata, obs_rdata;
  bit          obs_ready, obs_stall, obs_halted, obs_rvalid;

  function automatic logic [31:0] sh_word(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {sh[b | 10'd3], sh[b | 10'd2], sh[b | 10'd1], sh[b]};
  endfunction

  task automatic sh_write(input logic [1:0] be, input logic [31:0] a, input logic [31:0] d);
    int base;
    if (be == SZ_BYTE) sh[a[9:0]] = d[7:0];
    else if (be == SZ_HALF) begin
      base = int'(a[9:0]) & ~1;
      sh[base] = d[7:0]; sh[base + 1] = d[15:8];
    end else if (be == SZ_WORD) begin
      base = int'(a[9:0]) & ~3;
      for (int k = 0; k < 4; k++) sh[base + k] = d[8*k +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict, sample at negedge, advance model at posedge
  task automatic cycle();
    bit g_dbg, s_cpu, g_cpu, e_wen;
    int age;
    logic [31:0] rd;
    age   = m_pending ? (cyc - m_since) : 0;
    g_dbg = idbg_valid & (m_halted | !icpu_req | (age >= MW));
    s_cpu = icpu_req & (g_dbg | m_halted);
    g_cpu = icpu_req & !s_cpu;
    e_wen = g_dbg ? idbg_wen : (g_cpu & icpu_wen);
    @(negedge iclk);
    obs_ready = odbg_ready; obs_stall = ocpu_stall; obs_halted = ohalted;
    obs_rvalid = odbg_rvalid; obs_rdata = odbg_rdata; obs_cpu_rdata = ocpu_rdata;
    if (known) begin
      chk("ready", 32'(odbg_ready), 32'(g_dbg));
      chk("stall", 32'(ocpu_stall), 32'(s_cpu));
      chk("halted", 32'(ohalted), 32'(m_halted));
      chk("rvalid", 32'(odbg_rvalid), 32'(m_rvalid));
      chk("dbg_rdata", odbg_rdata, m_rdata);
      chk("mem_wen", 32'(omem_wen), 32'(e_wen));
      if (g_dbg) begin
        chk("mem_addr_dbg", omem_addr, idbg_addr);
        chk("mem_be_dbg", 32'(omem_be), 32'(idbg_be));
        if (idbg_wen) chk("mem_wdata_dbg", omem_wdata, idbg_wdata);
      end else if (g_cpu) begin
        chk("mem_addr_cpu", omem_addr, icpu_addr);
        chk("mem_be_cpu", 32'(omem_be), 32'(icpu_be));
        if (icpu_wen) chk("mem_wdata_cpu", omem_wdata, icpu_wdata);
        else chk("cpu_rdata", ocpu_rdata, sh_word(icpu_addr));
      end
    end
    @(posedge iclk);
    rd = sh_word(idbg_addr);
    if (g_dbg && idbg_wen) sh_write(idbg_be, idbg_addr, idbg_wdata);
    else if (g_cpu && icpu_wen) sh_write(icpu_be, icpu_addr, icpu_wdata);
    if (irst) begin
      known = 1; m_halted = 0; m_pending = 0; m_rvalid = 0; m_rdata = 0;
    end else begin
      m_rvalid = g_dbg & !idbg_wen;
      if (m_rvalid) m_rdata = rd;
      if (!m_halted && idbg_valid && !g_dbg) begin
        if (!m_pending) begin m_pending = 1; m_since = cyc; end
      end else m_pending = 0;
      m_halted = idbg_halt;
    end
    m_last_gdbg = g_dbg;
    m_last_stall = s_cpu;
    cyc++;
    #1;
  endtask

  task automatic cpu_set(input bit req, input bit wen, input logic [1:0] be,
                         input logic [31:0] a, input logic [31:0] d);
    icpu_req = req; icpu_wen = wen; icpu_be = be; icpu_addr = a; icpu_wdata = d;
  endtask

  task automatic dbg_set(input bit v, input bit wen, input logic [1:0] be,
                         input logic [31:0] a, input logic [31:0] d);
    idbg_valid = v; idbg_wen = wen; idbg_be = be; idbg_addr = a; idbg_wdata = d;
  endtask

  task automatic rnd_payload(input int lo, input int hi, output bit wen, output logic [1:0] be,
                             output logic [31:0] a, output logic [31:0] d);
    int sz;
    sz  = int'($urandom_range(0, 2));
    be  = 2'(sz);
    wen = 1'($urandom_range(0, 1));
    a   = 32'($urandom_range(lo, hi)) << 2;
    if (sz == 0) a = a + 32'($urandom_range(0, 3));
    else if (sz == 1) a = a + 32'($urandom_range(0, 1) * 2);
    d   = $urandom;
  endtask

  initial begin
    bit w; logic [1:0] b; logic [31:0] a, d;
    int first, accepts;
    for (int i = 0; i < 1024; i++) begin env_mem[i] = 8'h00; sh[i] = 8'h00; end
    irst = 1; idbg_halt = 0;
    cpu_set(0, 0, SZ_WORD, 0, 0); dbg_set(0, 0, SZ_WORD, 0, 0);
    #2;

    // Reset held two cycles with inputs toggling
    rnd_payload(128, 255, w, b, a, d); cpu_set(1, 0, b, a, d);
    rnd_payload(128, 255, w, b, a, d); dbg_set(1, 0, b, a, d); idbg_halt = 1;
    cycle();
    rnd_payload(128, 255, w, b, a, d); cpu_set(1'($urandom_range(0, 1)), w, b, a, d);
    rnd_payload(128, 255, w, b, a, d); dbg_set(1'($urandom_range(0, 1)), w, b, a, d);
    idbg_halt = 0;
    cycle();
    irst = 0; idbg_halt = 0;
    cpu_set(0, 0, SZ_WORD, 0, 0); dbg_set(0, 0, SZ_WORD, 0, 0);
    cycle();
    chk("t1_halted", 32'(obs_halted), 0);
    chk("t1_rvalid", 32'(obs_rvalid), 0);
    chk("t1_rdata", obs_rdata, 0);
    chk("t1_stall", 32'(obs_stall), 0);

    // CPU only
    cpu_set(1, 1, SZ_WORD, 32'h40, 32'hCAFEF00D); cycle();
    chk("t2_wr_stall", 32'(obs_stall), 0);
    cpu_set(1, 0, SZ_WORD, 32'h40, 0); cycle();
    chk("t2_rd_stall", 32'(obs_stall), 0);
    chk("t2_rdata", obs_cpu_rdata, 32'hCAFEF00D);
    cpu_set(0, 0, SZ_WORD, 0, 0);

    // Debug only, CPU idle
    dbg_set(1, 1, SZ_WORD, 32'h10, 32'hDEADBEEF); cycle();
    chk("t3_wr_ready", 32'(obs_ready), 1);
    dbg_set(1, 0, SZ_WORD, 32'h10, 0); cycle();
    chk("t3_rd_ready", 32'(obs_ready), 1);
    chk("t3_wr_no_rvalid", 32'(obs_rvalid), 0);
    dbg_set(0, 0, SZ_WORD, 0, 0); cycle();
    chk("t3_rvalid", 32'(obs_rvalid), 1);
    chk("t3_rdata", obs_rdata, 32'hDEADBEEF);
    cycle();
    chk("t3_rvalid_drop", 32'(obs_rvalid), 0);

    // Contention: CPU requests every cycle, debug read waits its turn
    first = -1;
    dbg_set(1, 0, SZ_WORD, 32'h40, 0);
    for (int i = 0; i < 10 && first < 0; i++) begin
      cpu_set(1, 1, SZ_WORD, 32'h80 + 32'(4 * i), 32'h5A000000 + 32'(i));
      cycle();
      if (obs_ready) begin
        first = i;
        chk("t4_stall", 32'(obs_stall), 1);
      end
    end
    chk("t4_first_ready", 32'(first), 32'(MW));
    dbg_set(0, 0, SZ_WORD, 0, 0);
    cpu_set(1, 0, SZ_WORD, 32'h80 + 32'(4 * MW), 0); cycle();
    chk("t4_dropped_write", obs_cpu_rdata, 0);
    chk("t4_rvalid", 32'(obs_rvalid), 1);
    chk("t4_rdata", obs_rdata, 32'hCAFEF00D);

    // Halt for bulk load
    idbg_halt = 1; cpu_set(1, 0, SZ_WORD, 32'h40, 0); cycle();
    chk("t5_halted_c0", 32'(obs_halted), 0);
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      dbg_set(1, 1, SZ_WORD, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      cycle();
      if (obs_ready) accepts++;
      if (i == 0) chk("t5_halted_c1", 32'(obs_halted), 1);
    end
    chk("t5_accepts", 32'(accepts), 8);
    dbg_set(0, 0, SZ_WORD, 0, 0); idbg_halt = 0;
    cpu_set(1, 0, SZ_WORD, 32'h104, 0); cycle();
    chk("t5_stall_while_halted", 32'(obs_stall), 1);
    cycle();
    chk("t5_unhalted", 32'(obs_halted), 0);
    chk("t5_cpu_serviced", 32'(obs_stall), 0);
    chk("t5_cpu_rdata", obs_cpu_rdata, 32'h1001);

    // Reset while halted with a debug read being presented
    cpu_set(0, 0, SZ_WORD, 0, 0); idbg_halt = 1; cycle(); cycle();
    dbg_set(1, 0, SZ_WORD, 32'h104, 0); irst = 1; cycle();
    irst = 0; idbg_halt = 0;
    cpu_set(1, 1, SZ_WORD, 32'h300, 32'h5);
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      cycle();
      if (i == 0) begin
        chk("t6_halted", 32'(obs_halted), 0);
        chk("t6_no_rvalid", 32'(obs_rvalid), 0);
      end
      if (obs_ready) first = i;
    end
    chk("t6_reserve", 32'(first), 32'(MW));
    dbg_set(0, 0, SZ_WORD, 0, 0); cpu_set(0, 0, SZ_WORD, 0, 0); cycle();
    chk("t6_rvalid", 32'(obs_rvalid), 1);
    chk("t6_rdata", obs_rdata, 32'h1001);

    // Random traffic obeying the hold-until-accepted / hold-while-stalled rules
    for (int n = 0; n < 400; n++) begin
      if (!(idbg_valid && !m_last_gdbg)) begin
        rnd_payload(0, 255, w, b, a, d);
        dbg_set(1'($urandom_range(0, 1)), w, b, a, d);
      end
      if (!(icpu_req && m_last_stall)) begin
        rnd_payload(0, 255, w, b, a, d);
        cpu_set(($urandom_range(0, 3) != 0), w, b, a, d);
      end
      if ($urandom_range(0, 19) == 0) idbg_halt = ~idbg_halt;
      irst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    irst = 0; idbg_halt = 0;
    cpu_set(0, 0, SZ_WORD, 0, 0); dbg_set(0, 0, SZ_WORD, 0, 0);
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
